// File: rtl/arbitro_mem.sv
// Two-port arbiter sharing one memory port between a CPU and a program loader.
// Round-robin between eligible requesters, with a mandatory idle cycle between grants.
module arbitro_mem #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ld_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_stall
);

    typedef enum logic [1:0] {OCIOSO, ACESSO, CONCLUI} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

    state_t     state, state_nx;
    logic       owner_ld;
    logic       rr_ld;
    logic       lat_we;
    logic [2:0] cnt;
    logic       cpu_elig, ld_elig, pick_ld, grant, cpu_wins;

    always_comb begin
        cpu_elig = cpu_req & ~ld_lock;
        ld_elig  = ld_req;
        pick_ld  = ld_elig & (~cpu_elig | rr_ld);
        grant    = (state == OCIOSO) & (cpu_elig | ld_elig);
        cpu_wins = grant & ~pick_ld;
    end

    always_comb begin
        state_nx = state;
        case (state)
            OCIOSO:  if (grant) state_nx = ACESSO;
            ACESSO:  if (lat_we || cnt == 3'd0) state_nx = CONCLUI;
            CONCLUI: state_nx = OCIOSO;
            default: state_nx = OCIOSO;
        endcase
    end

    always_comb begin
        cpu_gnt   = (state != OCIOSO) & ~owner_ld;
        ld_gnt    = (state != OCIOSO) &  owner_ld;
        cpu_done  = (state == CONCLUI) & ~owner_ld;
        ld_done   = (state == CONCLUI) &  owner_ld;
        mem_write = (state == ACESSO) & lat_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OCIOSO;
        else        state <= state_nx;
    end

    // The latched address/data registers double as the memory port outputs,
    // so they naturally hold their last value outside ACESSO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_ld  <= 1'b0;
            rr_ld     <= 1'b0;
            lat_we    <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else if (grant) begin
            owner_ld  <= pick_ld;
            rr_ld     <= ~pick_ld;
            lat_we    <= pick_ld ? ld_we    : cpu_we;
            mem_addr  <= pick_ld ? ld_addr  : cpu_addr;
            mem_wdata <= pick_ld ? ld_wdata : cpu_wdata;
            cnt       <= LAT_M1;
        end else if (state == ACESSO && !lat_we) begin
            if (cnt == 3'd0) begin
                if (owner_ld) ld_rdata  <= mem_rdata;
                else          cpu_rdata <= mem_rdata;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // The cycle in which the CPU wins arbitration is not a stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cpu_stall <= '0;
        else if (cpu_req && !cpu_gnt && !cpu_wins && cpu_stall != 16'hFFFF)
            cpu_stall <= cpu_stall + 16'd1;
    end

endmodule

// File: tb/tb_arbitro_mem.sv
// Scoreboard bench for arbitro_mem: expected owner/read data queued at launch,
// checked when the matching done pulse appears.
module tb_arbitro_mem;
    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, ld_req, ld_we, ld_lock;
    logic [AW-1:0] cpu_addr, ld_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, ld_wdata, mem_wdata, mem_rdata, cpu_rdata, ld_rdata;
    logic          cpu_gnt, cpu_done, ld_gnt, ld_done, mem_write;
    logic [15:0]   cpu_stall;

    logic [DW-1:0] mem [0:127];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int vectors = 0;
    int miscompares = 0;
    logic          exp_owner_q[$];
    logic [DW-1:0] exp_data_q[$];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pre_we)         mem[pre_addr] <= pre_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    arbitro_mem #(.ADDR_W(AW), .DATA_W(DW), .LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .ld_lock(ld_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic preload();
        @(negedge clk);
        pre_we = 1; pre_addr = 7'h05; pre_data = 32'hDEADBEEF;
        @(negedge clk);
        pre_we = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #1;
        vectors++;
        if ({cpu_gnt, ld_gnt, cpu_done, ld_done, mem_write} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000", {cpu_gnt, ld_gnt, cpu_done, ld_done, mem_write});
        end
        vectors++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_mem: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        vectors++;
        if (cpu_rdata !== '0 || ld_rdata !== '0 || cpu_stall !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got cpu_rdata=%h ld_rdata=%h stall=%h want 0", cpu_rdata, ld_rdata, cpu_stall);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_cpu_read();
        int done_cyc = 0;
        logic gnt1 = 0, gnt2 = 0;
        exp_owner_q.push_back(1'b0);
        exp_data_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h05;
        for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                gnt1 = cpu_gnt;
                vectors++;
                if (mem_addr !== 7'h05 || mem_write !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_port: got addr=%h we=%b want 05/0", mem_addr, mem_write);
                end
            end
            if (c == 2) gnt2 = cpu_gnt;
            if (cpu_done) begin
                done_cyc = c;
                cpu_req = 0;
                vectors++;
                if (exp_owner_q.pop_front() !== 1'b0 || cpu_rdata !== exp_data_q.pop_front()) begin
                    miscompares++;
                    $display("FAIL read_data: got cpu_rdata=%h want deadbeef", cpu_rdata);
                end
            end
        end
        vectors++;
        if (done_cyc != 2 || !gnt1 || !gnt2) begin
            miscompares++;
            $display("FAIL read_timing: got done_cycle=%0d gnt=%b%b want 2 and 11", done_cyc, gnt1, gnt2);
        end
        @(negedge clk);
        vectors++;
        if (cpu_gnt !== 1'b0 || cpu_done !== 1'b0 || cpu_stall !== 16'd0) begin
            miscompares++;
            $display("FAIL read_after: got gnt=%b done=%b stall=%0d want 0/0/0", cpu_gnt, cpu_done, cpu_stall);
        end
    endtask

    task automatic test_simultaneous();
        int cpu_done_c = 0, ld_first = 0, ld_done_c = 0;
        logic overlap = 0;
        do_reset();
        exp_owner_q.push_back(1'b0);
        exp_owner_q.push_back(1'b1);
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h0A; cpu_wdata = 32'hA5A50001;
        ld_req  = 1; ld_we  = 1; ld_addr  = 7'h0B; ld_wdata  = 32'h5A5A0002;
        for (int c = 1; c <= 20 && ld_done_c == 0; c++) begin
            @(negedge clk);
            if (cpu_gnt && ld_gnt) overlap = 1;
            if (c == 1) begin
                vectors++;
                if (mem_write !== 1'b1 || mem_addr !== 7'h0A || mem_wdata !== 32'hA5A50001) begin
                    miscompares++;
                    $display("FAIL sim_port: got we=%b addr=%h wdata=%h want 1/0a/a5a50001", mem_write, mem_addr, mem_wdata);
                end
                cpu_wdata = 32'hFFFFFFFF;
                cpu_addr  = 7'h7F;
            end
            if (ld_gnt && ld_first == 0) ld_first = c;
            if (cpu_done || ld_done) begin
                vectors++;
                if (exp_owner_q.pop_front() !== ld_done) begin
                    miscompares++;
                    $display("FAIL sim_order: got owner_ld=%b at cycle %0d", ld_done, c);
                end
            end
            if (cpu_done) begin cpu_done_c = c; cpu_req = 0; end
            if (ld_done)  begin ld_done_c = c;  ld_req = 0;  end
        end
        vectors++;
        if (cpu_done_c != 2 || ld_first != 4 || ld_done_c != 5 || overlap) begin
            miscompares++;
            $display("FAIL sim_timing: got cpu_done=%0d ld_gnt=%0d ld_done=%0d overlap=%b want 2/4/5/0", cpu_done_c, ld_first, ld_done_c, overlap);
        end
        vectors++;
        if (cpu_stall !== 16'd0) begin
            miscompares++;
            $display("FAIL sim_stall: got %0d want 0", cpu_stall);
        end
        vectors++;
        if (mem[10] !== 32'hA5A50001 || mem[11] !== 32'h5A5A0002) begin
            miscompares++;
            $display("FAIL sim_mem: got %h %h want a5a50001 5a5a0002", mem[10], mem[11]);
        end
    endtask

    task automatic test_fairness();
        int n_done = 0;
        for (int i = 0; i < 6; i++) begin
            exp_owner_q.push_back(1'(i % 2));
            exp_data_q.push_back(32'hDEADBEEF);
        end
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h05;
        ld_req  = 1; ld_we  = 0; ld_addr  = 7'h05;
        for (int c = 1; c <= 60 && n_done < 6; c++) begin
            @(negedge clk);
            if (cpu_done || ld_done) begin
                n_done++;
                vectors++;
                if (exp_owner_q.pop_front() !== ld_done || (ld_done ? ld_rdata : cpu_rdata) !== exp_data_q.pop_front()) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d: got owner_ld=%b rdata=%h", n_done, ld_done, ld_done ? ld_rdata : cpu_rdata);
                end
                if (n_done == 6) begin cpu_req = 0; ld_req = 0; end
            end
        end
        vectors++;
        if (n_done != 6) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d transactions want 6", n_done);
            idle_inputs();
        end
    endtask

    task automatic test_lock();
        logic gnt_seen = 0;
        int done_c = 0;
        do_reset();
        @(negedge clk);
        ld_lock = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h14; cpu_wdata = 32'h12345678;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cpu_gnt) gnt_seen = 1;
        end
        vectors++;
        if (gnt_seen || cpu_stall !== 16'd10) begin
            miscompares++;
            $display("FAIL lock_block: got gnt_seen=%b stall=%0d want 0/10", gnt_seen, cpu_stall);
        end
        ld_lock = 0;
        @(negedge clk);
        vectors++;
        if (cpu_gnt !== 1'b1 || cpu_stall !== 16'd10) begin
            miscompares++;
            $display("FAIL lock_release: got gnt=%b stall=%0d want 1/10", cpu_gnt, cpu_stall);
        end
        for (int c = 1; c <= 10 && done_c == 0; c++) begin
            @(negedge clk);
            if (cpu_done) begin done_c = c; cpu_req = 0; end
        end
        vectors++;
        if (done_c != 1 || mem[20] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL lock_done: got done_cycle=%0d mem=%h want 1/12345678", done_c, mem[20]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic done_seen = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h1E; cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        vectors++;
        if (mem_write !== 1'b1 || cpu_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midw_access: got we=%b gnt=%b want 1/1", mem_write, cpu_gnt);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({cpu_gnt, ld_gnt, cpu_done, ld_done, mem_write} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL midw_reset: got ctrl=%b addr=%h wdata=%h want 0", {cpu_gnt, ld_gnt, cpu_done, ld_done, mem_write}, mem_addr, mem_wdata);
        end
        vectors++;
        if (cpu_rdata !== '0 || ld_rdata !== '0 || cpu_stall !== 16'd0) begin
            miscompares++;
            $display("FAIL midw_regs: got cpu_rdata=%h ld_rdata=%h stall=%0d want 0", cpu_rdata, ld_rdata, cpu_stall);
        end
        cpu_req = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1;
            if (cpu_done) done_seen = 1;
        end
        vectors++;
        if (done_seen || mem[30] === 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL midw_abort: got done_seen=%b mem=%h want 0/not cafef00d", done_seen, mem[30]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        ld_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 7'h05;
        repeat (65540) @(negedge clk);
        vectors++;
        if (cpu_stall !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_reach: got %h want ffff", cpu_stall);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (cpu_stall !== 16'hFFFF || cpu_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_hold: got stall=%h gnt=%b want ffff/0", cpu_stall, cpu_gnt);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        preload();
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_fairness();
        test_lock();
        test_reset_mid_write();
        test_cpu_read();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
